impact_head_sequencer: RTL and testbench

Pad-side access sequencer driving the control and data pins of the IMPACT memory head (PreCharge, WL_enable, ReadEnable, WriteEnable, Data_In_Enable, select and mode pins) from a simple valid/ready request port. It generates the required phase order per access: setup, precharge, word-line access and sense. It captures Data_Out on reads and returns a single-cycle response. It sits between the test controller (FPGA or on-chip logic) and the head's pin interface, as the initiator for that interface.

---
 rtl/impact_head_sequencer_pkg.sv | 47 ++++
 rtl/impact_head_sequencer_if.sv | 34 +++
 rtl/impact_head_sequencer_timer.sv | 34 +++
 rtl/impact_head_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_impact_head_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/impact_head_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// impact_seq_pkg
// Shared types and constants for the IMPACT head access sequencer.
//   - state_t   : sequencer FSM states (verify states exist only when
//                 IMPACT_SEQ_VERIFY_EN is defined)
//   - req_t     : registered request fields
//   - CNT_W     : phase counter width
//   - *_CYC_DEF : default phase lengths
// Optional feature macro: IMPACT_SEQ_VERIFY_EN (write read-back verify).
// -----------------------------------------------------------------------------
package impact_seq_pkg;

  localparam int unsigned CNT_W         = 4;
  localparam int unsigned PRE_CYC_DEF   = 2;
  localparam int unsigned WL_CYC_DEF    = 2;
  localparam int unsigned SENSE_CYC_DEF = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_PRE,
    S_ACC,
    S_SENSE,
    S_DONE
`ifdef IMPACT_SEQ_VERIFY_EN
    ,
    S_VPRE,
    S_VACC,
    S_VSENSE
`endif
  } state_t;

  typedef struct packed {
    logic       write;
    logic [1:0] proj;
    logic [1:0] byte_sel;
    logic       byte_mode;
    logic       trunc;
    logic [7:0] wdata;
  } req_t;

  // A phase of N cycles loads N-1 and exits when the counter reads zero.
  function automatic logic [CNT_W-1:0] phase_load(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/impact_head_sequencer_if.sv
// -----------------------------------------------------------------------------
// impact_head_sequencer_if
// Request/response port of the IMPACT head sequencer.
//   req_valid/req_ready handshake plus request fields (write, proj, byte_sel,
//   byte_mode, trunc, wdata); rsp_valid one-cycle completion with rsp_rdata
//   and rsp_err.
//   master : test controller side (drives requests)
//   slave  : sequencer side
// -----------------------------------------------------------------------------
interface impact_head_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_proj;
  logic [1:0] req_byte_sel;
  logic       req_byte_mode;
  logic       req_trunc;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  modport master (
    output req_valid, req_write, req_proj, req_byte_sel, req_byte_mode,
           req_trunc, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_proj, req_byte_sel, req_byte_mode,
           req_trunc, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/impact_head_sequencer_timer.sv
// -----------------------------------------------------------------------------
// impact_seq_timer
// Loadable 4-bit down-counter with zero flag, shared by all sequencer phases.
//   clk, rst     : clock, asynchronous active-low reset
//   i_load       : load i_load_val this cycle (has priority over counting)
//   i_load_val   : value to load
//   o_zero       : counter is zero (phase finished)
// The counter stops at zero, so it idles at zero between phases.
// -----------------------------------------------------------------------------
module impact_seq_timer
  import impact_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/impact_head_sequencer.sv
// -----------------------------------------------------------------------------
// impact_head_sequencer
// Pad-side access sequencer for the IMPACT memory head. Accepts one request at
// a time on the bus port and walks SETUP -> PRECHARGE -> ACCESS (-> SENSE for
// reads) -> DONE, driving the head pins, capturing Data_Out on reads and
// issuing a one-cycle rsp_valid.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   bus (slave)         : request/response port
//   busy                : sequencer not idle
//   PreCharge, WL_enable, ReadEnable, WriteEnable, Data_In_Enable,
//   Byte_Mode_Enable, Trunc_Enable, Proj_Select, Byte_Select, Data_In
//                       : head pins (all registered)
//   Data_Out            : head read data
// Optional: IMPACT_SEQ_VERIFY_EN adds a read-back verify after every write;
// a mismatch sets rsp_err with rsp_valid. Without it rsp_err is tied low.
// -----------------------------------------------------------------------------
module impact_head_sequencer
  import impact_seq_pkg::*;
#(
  parameter int unsigned PRE_CYC   = PRE_CYC_DEF,
  parameter int unsigned WL_CYC    = WL_CYC_DEF,
  parameter int unsigned SENSE_CYC = SENSE_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  impact_head_sequencer_if.slave bus,
  output logic                   busy,
  output logic                   PreCharge,
  output logic                   WL_enable,
  output logic                   ReadEnable,
  output logic                   WriteEnable,
  output logic                   Data_In_Enable,
  output logic                   Byte_Mode_Enable,
  output logic                   Trunc_Enable,
  output logic [1:0]             Proj_Select,
  output logic [1:0]             Byte_Select,
  output logic [7:0]             Data_In,
  input  logic [7:0]             Data_Out
);

  localparam logic [CNT_W-1:0] PRE_LD   = phase_load(PRE_CYC);
  localparam logic [CNT_W-1:0] WL_LD    = phase_load(WL_CYC);
  localparam logic [CNT_W-1:0] SENSE_LD = phase_load(SENSE_CYC);

  state_t           r_state, w_state_next;
  req_t             r_req;
  logic             r_ready, r_busy, r_rsp_valid;
  logic             r_pre, r_wl, r_re, r_we, r_die;
  logic [7:0]       r_rdata;
  logic             w_accept, w_write, w_zero, w_load, w_capture;
  logic [CNT_W-1:0] w_load_val;
  logic             w_pre, w_wl, w_re, w_we, w_die;

  impact_seq_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  // Next state and timer loads
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_capture    = 1'b0;
    unique case (r_state)
      S_IDLE: if (bus.req_valid && r_ready) begin
        w_accept     = 1'b1;
        w_state_next = S_SETUP;
      end
      S_SETUP: begin
        w_state_next = S_PRE;
        w_load       = 1'b1;
        w_load_val   = PRE_LD;
      end
      S_PRE: if (w_zero) begin
        w_state_next = S_ACC;
        w_load       = 1'b1;
        w_load_val   = WL_LD;
      end
      S_ACC: if (w_zero) begin
        if (!r_req.write) begin
          w_state_next = S_SENSE;
          w_load       = 1'b1;
          w_load_val   = SENSE_LD;
        end else begin
`ifdef IMPACT_SEQ_VERIFY_EN
          w_state_next = S_VPRE;
          w_load       = 1'b1;
          w_load_val   = PRE_LD;
`else
          w_state_next = S_DONE;
`endif
        end
      end
      S_SENSE: if (w_zero) begin
        w_state_next = S_DONE;
        w_capture    = 1'b1;
      end
`ifdef IMPACT_SEQ_VERIFY_EN
      S_VPRE: if (w_zero) begin
        w_state_next = S_VACC;
        w_load       = 1'b1;
        w_load_val   = WL_LD;
      end
      S_VACC: if (w_zero) begin
        w_state_next = S_VSENSE;
        w_load       = 1'b1;
        w_load_val   = SENSE_LD;
      end
      S_VSENSE: if (w_zero) begin
        w_state_next = S_DONE;
        w_capture    = 1'b1;
      end
`endif
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Pin decode from the next state; registering it makes every pin line up
  // with its state cycle while staying glitch-free. On the accept edge the
  // request is not yet in r_req, so the write flag comes from the bus.
  assign w_write = w_accept ? bus.req_write : r_req.write;

  always_comb begin
    w_pre = 1'b0;
    w_wl  = 1'b0;
    w_re  = 1'b0;
    w_we  = 1'b0;
    w_die = 1'b0;
    unique case (w_state_next)
      S_SETUP: w_die = w_write;
      S_PRE: begin
        w_pre = 1'b1;
        w_die = w_write;
      end
      S_ACC: begin
        w_wl  = 1'b1;
        w_we  = w_write;
        w_re  = !w_write;
        w_die = w_write;
      end
      S_SENSE: w_re = 1'b1;
`ifdef IMPACT_SEQ_VERIFY_EN
      S_VPRE: w_pre = 1'b1;
      S_VACC: begin
        w_wl = 1'b1;
        w_re = 1'b1;
      end
      S_VSENSE: w_re = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_pre       <= 1'b0;
      r_wl        <= 1'b0;
      r_re        <= 1'b0;
      r_we        <= 1'b0;
      r_die       <= 1'b0;
      r_rdata     <= '0;
      r_req       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_ready     <= (w_state_next == S_IDLE);
      r_busy      <= (w_state_next != S_IDLE);
      r_rsp_valid <= (w_state_next == S_DONE);
      r_pre       <= w_pre;
      r_wl        <= w_wl;
      r_re        <= w_re;
      r_we        <= w_we;
      r_die       <= w_die;
      if (w_accept) begin
        r_req.write     <= bus.req_write;
        r_req.proj      <= bus.req_proj;
        r_req.byte_sel  <= bus.req_byte_sel;
        r_req.byte_mode <= bus.req_byte_mode;
        r_req.trunc     <= bus.req_trunc;
        // Data_In keeps its last write value across reads.
        if (bus.req_write) r_req.wdata <= bus.req_wdata;
      end
      if (w_capture) r_rdata <= Data_Out;
    end
  end

`ifdef IMPACT_SEQ_VERIFY_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else      r_err <= (r_state == S_VSENSE) && w_zero && (Data_Out != r_req.wdata);
  end
  assign bus.rsp_err = r_err;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready    = r_ready;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rdata    = r_rdata;
  assign busy             = r_busy;
  assign PreCharge        = r_pre;
  assign WL_enable        = r_wl;
  assign ReadEnable       = r_re;
  assign WriteEnable      = r_we;
  assign Data_In_Enable   = r_die;
  assign Proj_Select      = r_req.proj;
  assign Byte_Select      = r_req.byte_sel;
  assign Byte_Mode_Enable = r_req.byte_mode;
  assign Trunc_Enable     = r_req.trunc;
  assign Data_In          = r_req.wdata;

endmodule

// File: tb/tb_impact_head_sequencer.sv
// -----------------------------------------------------------------------------
// tb_impact_head_sequencer
// Directed bench for impact_head_sequencer with a response scoreboard and a
// simple head model: Data_Out returns rd_val while the head is sensing
// (ReadEnable without WL_enable) and 0xFF otherwise.
// Honours IMPACT_SEQ_VERIFY_EN for write latency and response expectations.
// -----------------------------------------------------------------------------
module tb_impact_head_sequencer;
  import impact_seq_pkg::*;

`ifdef IMPACT_SEQ_VERIFY_EN
  localparam bit VERIFY  = 1'b1;
  localparam int WR_LAT  = 11;
  localparam int WR_NPRE = 4;
`else
  localparam bit VERIFY  = 1'b0;
  localparam int WR_LAT  = 6;
  localparam int WR_NPRE = 2;
`endif
  localparam int RD_LAT = 7;

  logic       clk, rst;
  logic       busy, PreCharge, WL_enable, ReadEnable, WriteEnable;
  logic       Data_In_Enable, Byte_Mode_Enable, Trunc_Enable;
  logic [1:0] Proj_Select, Byte_Select;
  logic [7:0] Data_In, Data_Out;
  logic [7:0] rd_val;

  impact_head_sequencer_if bus ();

  impact_head_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus.slave),
    .busy             (busy),
    .PreCharge        (PreCharge),
    .WL_enable        (WL_enable),
    .ReadEnable       (ReadEnable),
    .WriteEnable      (WriteEnable),
    .Data_In_Enable   (Data_In_Enable),
    .Byte_Mode_Enable (Byte_Mode_Enable),
    .Trunc_Enable     (Trunc_Enable),
    .Proj_Select      (Proj_Select),
    .Byte_Select      (Byte_Select),
    .Data_In          (Data_In),
    .Data_Out         (Data_Out)
  );

  assign Data_Out = (ReadEnable && !WL_enable) ? rd_val : 8'hFF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_overlap_pw = 0;
  int         n_overlap_rw = 0;
  logic [8:0] sb[$];
  logic [7:0] cur_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer and pin invariants.
  always @(negedge clk) begin
    if (rst) begin
      if (PreCharge && WL_enable)    n_overlap_pw++;
      if (ReadEnable && WriteEnable) n_overlap_rw++;
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", sb.size(), 1);
        end else begin
          logic [8:0] e;
          e = sb.pop_front();
          check("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, e[8:1]});
          check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e[0]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int         lat, n_pre, n_wlwe, n_wlre, n_sense, n_die, n_din_bad;
  logic [5:0] sel1;

  // One complete access from idle; counts pin activity per cycle until rsp.
  task automatic access(input logic wr, input logic [1:0] proj, input logic [1:0] bsel,
                        input logic bm, input logic tr, input logic [7:0] wd);
    logic [7:0] exp_rd;
    logic       exp_err;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_proj = proj;
    bus.req_byte_sel = bsel; bus.req_byte_mode = bm; bus.req_trunc = tr;
    bus.req_wdata = wd;
    @(posedge clk);
    if (!wr || VERIFY) exp_rd = rd_val; else exp_rd = cur_rdata;
    exp_err   = wr && VERIFY && (rd_val != wd);
    cur_rdata = exp_rd;
    sb.push_back({exp_rd, exp_err});
    #1 bus.req_valid = 1'b0;
    lat = 0; n_pre = 0; n_wlwe = 0; n_wlre = 0; n_sense = 0; n_die = 0; n_din_bad = 0;
    sel1 = '0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      if (PreCharge)                n_pre++;
      if (WL_enable && WriteEnable) n_wlwe++;
      if (WL_enable && ReadEnable)  n_wlre++;
      if (ReadEnable && !WL_enable) n_sense++;
      if (Data_In_Enable) begin
        n_die++;
        if (Data_In !== wd) n_din_bad++;
      end
      if (c == 1) sel1 = {Proj_Select, Byte_Select, Byte_Mode_Enable, Trunc_Enable};
      if (bus.rsp_valid) lat = c;
    end
    @(negedge clk);
    check("rsp_single_cycle", {31'd0, bus.rsp_valid}, 32'd0);
    check("ready_after_done", {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    int done_c, rdy_c, n_stall_bad, found, n_spur, lat2;
    logic [5:0] sel_done;
    rst = 1'b1;
    rd_val = 8'h00;
    cur_rdata = 8'h00;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_proj = '0;
    bus.req_byte_sel = '0; bus.req_byte_mode = 1'b0; bus.req_trunc = 1'b0;
    bus.req_wdata = '0;

    // Reset values
    #1 rst = 1'b0;
    #1;
    check("reset_outputs", {2'd0, PreCharge, WL_enable, ReadEnable, WriteEnable, Data_In_Enable,
                            Byte_Mode_Enable, Trunc_Enable, Proj_Select, Byte_Select, Data_In,
                            bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, busy}, 32'd0);
    check("reset_ready", {31'd0, bus.req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_outputs", {2'd0, PreCharge, WL_enable, ReadEnable, WriteEnable, Data_In_Enable,
                           Byte_Mode_Enable, Trunc_Enable, Proj_Select, Byte_Select, Data_In,
                           bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, busy}, 32'd0);
    check("idle_ready", {31'd0, bus.req_ready}, 32'd1);

    // Read, head returns 0x3C while sensing
    rd_val = 8'h3C;
    access(1'b0, 2'd1, 2'd3, 1'b0, 1'b1, 8'h77);
    check("rd_latency", lat, RD_LAT);
    check("rd_precharge_cycles", n_pre, 2);
    check("rd_wl_re_cycles", n_wlre, 2);
    check("rd_sense_cycles", n_sense, 1);
    check("rd_die_cycles", n_die, 0);
    check("rd_sel_pins", {26'd0, sel1}, {26'd0, 2'd1, 2'd3, 1'b0, 1'b1});

    // Write 0xA5, proj=2, byte_sel=1; read data must survive a plain write
    rd_val = 8'hA5;
    access(1'b1, 2'd2, 2'd1, 1'b1, 1'b1, 8'hA5);
    check("wr_latency", lat, WR_LAT);
    check("wr_die_cycles", n_die, 5);
    check("wr_data_in", n_din_bad, 0);
    check("wr_precharge_cycles", n_pre, WR_NPRE);
    check("wr_wl_we_cycles", n_wlwe, 2);
    check("wr_sel_pins", {26'd0, sel1}, {26'd0, 2'd2, 2'd1, 1'b1, 1'b1});
    check("wr_rdata_hold", {24'd0, bus.rsp_rdata}, {24'd0, cur_rdata});

    // Back-to-back reads with req_valid held; fields change during the stall
    rd_val = 8'h3C;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_proj = 2'd1;
    bus.req_byte_sel = 2'd0; bus.req_byte_mode = 1'b0; bus.req_trunc = 1'b1;
    @(posedge clk);
    sb.push_back({8'h3C, 1'b0});
    #1;
    bus.req_proj = 2'd3; bus.req_byte_sel = 2'd2; bus.req_byte_mode = 1'b1; bus.req_trunc = 1'b0;
    done_c = 0; rdy_c = 0; n_stall_bad = 0; sel_done = '0;
    for (int c = 1; c <= 30 && rdy_c == 0; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        done_c = c;
        sel_done = {Proj_Select, Byte_Select, Byte_Mode_Enable, Trunc_Enable};
        rd_val = 8'h5A;
      end else if (done_c != 0 && bus.req_ready) begin
        rdy_c = c;
      end else if (bus.req_ready) begin
        n_stall_bad++;
      end
    end
    check("b2b_first_latency", done_c, RD_LAT);
    check("b2b_accept_gap", rdy_c - done_c, 1);
    check("b2b_stall_ready_low", n_stall_bad, 0);
    check("b2b_first_sel_held", {26'd0, sel_done}, {26'd0, 2'd1, 2'd0, 1'b0, 1'b1});
    @(posedge clk);
    sb.push_back({8'h5A, 1'b0});
    cur_rdata = 8'h5A;
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("b2b_second_sel", {26'd0, Proj_Select, Byte_Select, Byte_Mode_Enable, Trunc_Enable},
          {26'd0, 2'd3, 2'd2, 1'b1, 1'b0});
    lat2 = 0;
    for (int c = 2; c <= 30 && lat2 == 0; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) lat2 = c;
    end
    check("b2b_second_latency", lat2, RD_LAT);

    // Reset during ACCESS of a write
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_proj = 2'd0;
    bus.req_byte_sel = 2'd0; bus.req_byte_mode = 1'b0; bus.req_trunc = 1'b0;
    bus.req_wdata = 8'hC3;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge clk);
      if (WL_enable) found = 1;
    end
    check("abort_reached_access", found, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_strobes", {25'd0, PreCharge, WL_enable, ReadEnable, WriteEnable,
                            Data_In_Enable, bus.rsp_valid, busy}, 32'd0);
    check("abort_ready", {31'd0, bus.req_ready}, 32'd1);
    cur_rdata = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    n_spur = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) n_spur++;
    end
    check("abort_no_rsp", n_spur, 0);
    rd_val = 8'h5A;
    access(1'b1, 2'd2, 2'd2, 1'b0, 1'b0, 8'h5A);
    check("post_abort_latency", lat, WR_LAT);
    check("post_abort_wl_we", n_wlwe, 2);

    // Write 0x0F; head reads back 0x0E (bit 0 corrupted)
    rd_val = 8'h0E;
    access(1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 8'h0F);
    check("vfy_latency", lat, WR_LAT);

    check("scoreboard_drained", sb.size(), 0);
    check("pre_wl_never_both", n_overlap_pw, 0);
    check("re_we_never_both", n_overlap_rw, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
